// File: rtl/ddr3_pkg.sv
// Shared DDR3 datapath constants and sizing helpers.
// Used by the read, write and stream-buffer blocks.
package ddr3_pkg;

   localparam int DDR3_DATA_W = 512;
   localparam int DDR3_OUT_W  = 128;

   function automatic int ratio(input int dw, input int ow);
      return dw / ow;
   endfunction

   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ddr3_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are not reset so the array maps onto block RAM.
module ddr3_sdp_ram #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdat,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdat
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdat;
      if (re)
         rdat <= mem[raddr];
   end

endmodule

// File: rtl/ddr3_rd_stream_buf.sv
// Buffers DDR3 read words and serialises them into narrow sub-beats.
// FIFO -> prefetch (RAM read register) -> hold -> out_dat register.
module ddr3_rd_stream_buf
   import ddr3_pkg::*;
#(
   parameter int DATA_WIDTH   = DDR3_DATA_W,
   parameter int OUT_WIDTH    = DDR3_OUT_W,
   parameter int FIFO_DEPTH   = 64,
   parameter int AFULL_THRESH = 48,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          in_vld,
   input  logic [DATA_WIDTH-1:0]         in_dat,
   output logic                          out_vld,
   input  logic                          out_rdy,
   output logic [OUT_WIDTH-1:0]          out_dat,
   output logic                          out_last,
   output logic [level_w(FIFO_DEPTH)-1:0] level,
   output logic                          afull,
   output logic                          empty,
   output logic                          ovf,
   output logic [CNT_WIDTH-1:0]          drop_cnt
);

   localparam int RATIO = ratio(DATA_WIDTH, OUT_WIDTH);
   localparam int LW    = level_w(FIFO_DEPTH);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);
   localparam logic [SW-1:0] SEL_LAST  = SW'(RATIO - 1);

   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] pf_dat, hold, hold_nxt;
   logic                  pf_vld, pf_vld_nxt;
   logic                  hold_vld, hold_vld_nxt;
   logic [SW-1:0]         sel, sel_nxt;
   logic [LW-1:0]         level_nxt;
   logic                  push, drop, pop;
   logic                  beat_acc, last_acc, hold_load;

   ddr3_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_W     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdat  (in_dat),
      .re    (pop),
      .raddr (rd_ptr),
      .rdat  (pf_dat)
   );

   assign out_vld  = hold_vld;
   assign out_last = hold_vld && (sel == SEL_LAST);

   // Fullness uses the registered level, so a same-cycle pop never rescues a push.
   always_comb begin
      push         = in_vld && !clr && (level != FULL_LVL);
      drop         = in_vld && !clr && (level == FULL_LVL);
      beat_acc     = hold_vld && out_rdy;
      last_acc     = beat_acc && (sel == SEL_LAST);
      hold_load    = pf_vld && (!hold_vld || last_acc);
      pop          = (level != '0) && (!pf_vld || hold_load);
      level_nxt    = level + LW'(push) - LW'(pop);
      pf_vld_nxt   = pop || (pf_vld && !hold_load);
      hold_vld_nxt = hold_load || (hold_vld && !last_acc);
      hold_nxt     = hold_load ? pf_dat : hold;
      sel_nxt      = sel;
      if (last_acc)
         sel_nxt = '0;
      else if (beat_acc)
         sel_nxt = sel + SW'(1);
      if (clr) begin
         level_nxt    = '0;
         pf_vld_nxt   = 1'b0;
         hold_vld_nxt = 1'b0;
         sel_nxt      = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         pf_vld   <= 1'b0;
         hold_vld <= 1'b0;
         hold     <= '0;
         sel      <= '0;
         out_dat  <= '0;
         afull    <= 1'b0;
         empty    <= 1'b1;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         level    <= level_nxt;
         pf_vld   <= pf_vld_nxt;
         hold_vld <= hold_vld_nxt;
         hold     <= hold_nxt;
         sel      <= sel_nxt;
         out_dat  <= hold_nxt[int'(sel_nxt)*OUT_WIDTH +: OUT_WIDTH];
         afull    <= (level_nxt >= AFULL_LVL);
         empty    <= (level_nxt == '0) && !pf_vld_nxt && !hold_vld_nxt;
         if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            if (drop) begin
               ovf <= 1'b1;
               if (drop_cnt != '1)
                  drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule
